fifo_v4: RTL and testbench

Parametrised successor FIFO with valid/ready handshakes on both sides. Adds a full-width occupancy count, static almost-full/almost-empty thresholds and optional per-entry parity. Depth may be any value ≥1, including non-powers-of-two. Drop-in buffering element for stream datapaths: between pipeline stages, CDC-adjacent buffering in the sync domain, request queues.

---
 rtl/fifo_v4_pkg.sv | 23 ++
 rtl/fifo_v4_ptr.sv | 44 ++++
 rtl/fifo_v4.sv | 163 ++++++++++++++++
 tb/tb_fifo_v4.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_v4_pkg.sv
// fifo_v4 shared definitions: derived width helpers and a generic parity function.
// Optional feature macro used by fifo_v4: FIFO_V4_PARITY_EN.
package fifo_v4_pkg;

   // Widest payload the generic parity helper accepts; callers zero-extend into it.
   localparam int unsigned MaxParityWidth = 1024;

   // Counter width able to hold 0..depth inclusive.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Pointer width; a single-entry FIFO still gets a 1-bit (constant) pointer.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Even parity (XOR reduction); zero-extension does not change the result.
   function automatic logic parity(input logic [MaxParityWidth-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/fifo_v4_ptr.sv
// fifo_v4_ptr: wrapping FIFO pointer with synchronous flush and increment enable.
// Wraps DEPTH-1 -> 0, so non-power-of-two depths are handled explicitly.
module fifo_v4_ptr import fifo_v4_pkg::*; #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned PTR_WIDTH = ptr_width(DEPTH)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush,
   input  logic                 incr,
   output logic [PTR_WIDTH-1:0] ptr
);

   if (DEPTH <= 1) begin : gen_const
      // A single entry never needs addressing; occupancy lives in the count alone.
      logic unused_ctrl;
      assign unused_ctrl = ^{clk_i, rst_ni, flush, incr};
      assign ptr = '0;
   end else begin : gen_wrap
      logic [PTR_WIDTH-1:0] ptr_q, ptr_d;

      // Next pointer: flush wins, otherwise advance with wrap at DEPTH-1.
      always_comb begin
         ptr_d = ptr_q;
         if (flush) begin
            ptr_d = '0;
         end else if (incr) begin
            ptr_d = (ptr_q == PTR_WIDTH'(DEPTH - 1)) ? '0 : ptr_q + PTR_WIDTH'(1);
         end
      end

      // Pointer register.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            ptr_q <= '0;
         end else begin
            ptr_q <= ptr_d;
         end
      end

      assign ptr = ptr_q;
   end

endmodule

// File: rtl/fifo_v4.sv
// fifo_v4: valid/ready FIFO with full-width occupancy, almost-full/empty thresholds,
// optional fall-through and optional per-entry parity (macro FIFO_V4_PARITY_EN).
// All status outputs decode from the registered count only.
module fifo_v4 import fifo_v4_pkg::*; #(
   parameter bit          FALL_THROUGH = 1'b0,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned ALM_FULL_TH  = DEPTH - 1,
   parameter int unsigned ALM_EMPTY_TH = 1,
   parameter int unsigned CNT_WIDTH    = cnt_width(DEPTH),
   parameter int unsigned PTR_WIDTH    = ptr_width(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  testmode_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic [CNT_WIDTH-1:0]  usage_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  alm_full_o,
   output logic                  alm_empty_o,
   output logic                  parity_err_o
);

`ifdef FIFO_V4_PARITY_EN
   localparam int unsigned StoreWidth = DATA_WIDTH + 1;
`else
   localparam int unsigned StoreWidth = DATA_WIDTH;
`endif

   logic [StoreWidth-1:0] mem_q [DEPTH];
   logic [StoreWidth-1:0] wdata;
   logic [StoreWidth-1:0] head;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic [PTR_WIDTH-1:0]  wr_ptr, rd_ptr;
   logic                  full, empty;
   logic                  ft_active, bypass;
   logic                  push, pop, store, drain;

   // Clock-gating bypass hook only.
   logic unused_testmode;
   assign unused_testmode = testmode_i;

   // Handshake decode; bypassed words neither enter storage nor leave it.
   always_comb begin
      full        = (count_q == CNT_WIDTH'(DEPTH));
      empty       = (count_q == '0);
      ft_active   = FALL_THROUGH & empty & in_valid_i;
      head        = mem_q[rd_ptr];
      out_valid_o = ~empty | ft_active;
      out_data_o  = ft_active ? in_data_i : head[DATA_WIDTH-1:0];
      push        = in_valid_i & ~full;
      pop         = out_valid_o & out_ready_i;
      bypass      = ft_active & out_ready_i;
      store       = push & ~bypass;
      drain       = pop & ~bypass;
   end

   // Status outputs straight from the registered count.
   always_comb begin
      in_ready_o  = ~full;
      full_o      = full;
      empty_o     = empty;
      usage_o     = count_q;
      alm_full_o  = (count_q >= CNT_WIDTH'(ALM_FULL_TH));
      alm_empty_o = (count_q <= CNT_WIDTH'(ALM_EMPTY_TH));
   end

`ifdef FIFO_V4_PARITY_EN
   // Store even parity alongside the payload; bypass data is never checked.
   always_comb begin
      wdata        = {parity(MaxParityWidth'(in_data_i)), in_data_i};
      parity_err_o = ~empty & parity(MaxParityWidth'(head));
   end
`else
   // Payload-only storage, no parity reporting.
   always_comb begin
      wdata        = in_data_i;
      parity_err_o = 1'b0;
   end
`endif

   // Next count: flush clears, simultaneous store and drain leave it unchanged.
   always_comb begin
      count_d = count_q;
      if (flush_i) begin
         count_d = '0;
      end else if (store && !drain) begin
         count_d = count_q + CNT_WIDTH'(1);
      end else if (drain && !store) begin
         count_d = count_q - CNT_WIDTH'(1);
      end
   end

   // Occupancy register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Storage write; a flush discards the same-cycle push and leaves contents intact.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (store && !flush_i) begin
         mem_q[wr_ptr] <= wdata;
      end
   end

   fifo_v4_ptr #(
      .DEPTH     (DEPTH),
      .PTR_WIDTH (PTR_WIDTH)
   ) u_wr_ptr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .flush  (flush_i),
      .incr   (store),
      .ptr    (wr_ptr)
   );

   fifo_v4_ptr #(
      .DEPTH     (DEPTH),
      .PTR_WIDTH (PTR_WIDTH)
   ) u_rd_ptr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .flush  (flush_i),
      .incr   (drain),
      .ptr    (rd_ptr)
   );

`ifndef SYNTHESIS
   if (DEPTH < 1) begin : gen_depth_err
      $error("fifo_v4: DEPTH must be at least 1");
   end
   if (ALM_FULL_TH < 1 || ALM_FULL_TH > DEPTH) begin : gen_af_err
      $error("fifo_v4: ALM_FULL_TH must be within 1..DEPTH");
   end
   if (ALM_EMPTY_TH >= DEPTH) begin : gen_ae_err
      $error("fifo_v4: ALM_EMPTY_TH must be within 0..DEPTH-1");
   end

   a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
      store |-> in_ready_o);

   if (!FALL_THROUGH) begin : gen_stable_chk
      a_head_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
         (out_valid_o && !out_ready_i && !flush_i) |=> (out_valid_o && $stable(out_data_o)));
   end
`endif

endmodule

// File: tb/tb_fifo_v4.sv
// Directed bench for fifo_v4: three shared-stimulus instances (DEPTH=5, fall-through
// DEPTH=4, DEPTH=8 with custom thresholds), table-driven vectors plus corner sequences.
module tb_fifo_v4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush, testmode, in_valid, out_ready;
   logic [7:0] in_data;

   logic       d5_in_ready, d5_out_valid, d5_full, d5_empty, d5_af, d5_ae, d5_perr;
   logic [7:0] d5_out_data;
   logic [2:0] d5_usage;
   logic       ft_in_ready, ft_out_valid, ft_full, ft_empty, ft_af, ft_ae, ft_perr;
   logic [7:0] ft_out_data;
   logic [2:0] ft_usage;
   logic       d8_in_ready, d8_out_valid, d8_full, d8_empty, d8_af, d8_ae, d8_perr;
   logic [7:0] d8_out_data;
   logic [3:0] d8_usage;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fifo_v4 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(5)) u_d5 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(testmode),
      .in_valid_i(in_valid), .in_ready_o(d5_in_ready), .in_data_i(in_data),
      .out_valid_o(d5_out_valid), .out_ready_i(out_ready), .out_data_o(d5_out_data),
      .usage_o(d5_usage), .full_o(d5_full), .empty_o(d5_empty), .alm_full_o(d5_af),
      .alm_empty_o(d5_ae), .parity_err_o(d5_perr)
   );

   fifo_v4 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4)) u_ft (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(testmode),
      .in_valid_i(in_valid), .in_ready_o(ft_in_ready), .in_data_i(in_data),
      .out_valid_o(ft_out_valid), .out_ready_i(out_ready), .out_data_o(ft_out_data),
      .usage_o(ft_usage), .full_o(ft_full), .empty_o(ft_empty), .alm_full_o(ft_af),
      .alm_empty_o(ft_ae), .parity_err_o(ft_perr)
   );

   fifo_v4 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(8), .ALM_FULL_TH(6),
             .ALM_EMPTY_TH(2)) u_d8 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(testmode),
      .in_valid_i(in_valid), .in_ready_o(d8_in_ready), .in_data_i(in_data),
      .out_valid_o(d8_out_valid), .out_ready_i(out_ready), .out_data_o(d8_out_data),
      .usage_o(d8_usage), .full_o(d8_full), .empty_o(d8_empty), .alm_full_o(d8_af),
      .alm_empty_o(d8_ae), .parity_err_o(d8_perr)
   );

   typedef struct {
      logic       flush;
      logic       valid;
      logic [7:0] data;
      logic       ready;
      logic       ov;
      logic [7:0] od;
      int         usage;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic fl, input logic v, input logic [7:0] d,
                               input logic r, input logic ov, input logic [7:0] od,
                               input int usage);
      vec_t t;
      t.flush = fl; t.valid = v; t.data = d; t.ready = r;
      t.ov = ov; t.od = od; t.usage = usage;
      vecs.push_back(t);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic fl, input logic v, input logic [7:0] d, input logic r);
      flush = fl; in_valid = v; in_data = d; out_ready = r;
   endtask

   // Every instance should be empty with inputs idle.
   task automatic check_idle_all(input string tag);
      check({tag, " d5 in_ready"}, int'(d5_in_ready), 1);
      check({tag, " d5 out_valid"}, int'(d5_out_valid), 0);
      check({tag, " d5 usage"}, int'(d5_usage), 0);
      check({tag, " d5 full"}, int'(d5_full), 0);
      check({tag, " d5 empty"}, int'(d5_empty), 1);
      check({tag, " d5 alm_full"}, int'(d5_af), 0);
      check({tag, " d5 alm_empty"}, int'(d5_ae), 1);
      check({tag, " d5 parity_err"}, int'(d5_perr), 0);
      check({tag, " ft in_ready"}, int'(ft_in_ready), 1);
      check({tag, " ft out_valid"}, int'(ft_out_valid), 0);
      check({tag, " ft usage"}, int'(ft_usage), 0);
      check({tag, " ft full"}, int'(ft_full), 0);
      check({tag, " ft empty"}, int'(ft_empty), 1);
      check({tag, " ft alm_full"}, int'(ft_af), 0);
      check({tag, " ft alm_empty"}, int'(ft_ae), 1);
      check({tag, " ft parity_err"}, int'(ft_perr), 0);
      check({tag, " d8 in_ready"}, int'(d8_in_ready), 1);
      check({tag, " d8 out_valid"}, int'(d8_out_valid), 0);
      check({tag, " d8 usage"}, int'(d8_usage), 0);
      check({tag, " d8 full"}, int'(d8_full), 0);
      check({tag, " d8 empty"}, int'(d8_empty), 1);
      check({tag, " d8 alm_full"}, int'(d8_af), 0);
      check({tag, " d8 alm_empty"}, int'(d8_ae), 1);
      check({tag, " d8 parity_err"}, int'(d8_perr), 0);
   endtask

   task automatic flush_all();
      @(negedge clk); drive(1'b1, 1'b0, 8'h00, 1'b0);
      @(negedge clk); drive(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; testmode = 1'b0;
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      #2;
      check_idle_all("reset");
      @(negedge clk); rst_n = 1'b1;

      // DEPTH=5 vectors: {flush, valid, data, ready} -> head valid/data and usage
      // before the clock edge. Fill/drain, refuse-when-full even with pop.
      add(0, 0, 8'h00, 0, 0, 8'h00, 0);
      add(0, 1, 8'h11, 0, 0, 8'h00, 0);
      add(0, 1, 8'h12, 0, 1, 8'h11, 1);
      add(0, 1, 8'h13, 0, 1, 8'h11, 2);
      add(0, 1, 8'h14, 0, 1, 8'h11, 3);
      add(0, 1, 8'h15, 0, 1, 8'h11, 4);
      add(0, 1, 8'h99, 0, 1, 8'h11, 5);
      add(0, 1, 8'h99, 1, 1, 8'h11, 5);
      add(0, 0, 8'h00, 1, 1, 8'h12, 4);
      add(0, 0, 8'h00, 1, 1, 8'h13, 3);
      add(0, 0, 8'h00, 1, 1, 8'h14, 2);
      add(0, 0, 8'h00, 1, 1, 8'h15, 1);
      add(0, 0, 8'h00, 1, 0, 8'h00, 0);
      add(0, 0, 8'h00, 0, 0, 8'h00, 0);
      // Fill 3, then six push+pop cycles wrapping both pointers, then drain.
      add(0, 1, 8'h21, 0, 0, 8'h00, 0);
      add(0, 1, 8'h22, 0, 1, 8'h21, 1);
      add(0, 1, 8'h23, 0, 1, 8'h21, 2);
      add(0, 1, 8'h24, 1, 1, 8'h21, 3);
      add(0, 1, 8'h25, 1, 1, 8'h22, 3);
      add(0, 1, 8'h26, 1, 1, 8'h23, 3);
      add(0, 1, 8'h27, 1, 1, 8'h24, 3);
      add(0, 1, 8'h28, 1, 1, 8'h25, 3);
      add(0, 1, 8'h29, 1, 1, 8'h26, 3);
      add(0, 0, 8'h00, 1, 1, 8'h27, 3);
      add(0, 0, 8'h00, 1, 1, 8'h28, 2);
      add(0, 0, 8'h00, 1, 1, 8'h29, 1);
      add(0, 0, 8'h00, 0, 0, 8'h00, 0);
      // Flush at count 4 with a concurrent push; the 0x55 must never appear.
      add(0, 1, 8'h31, 0, 0, 8'h00, 0);
      add(0, 1, 8'h32, 0, 1, 8'h31, 1);
      add(0, 1, 8'h33, 0, 1, 8'h31, 2);
      add(0, 1, 8'h34, 0, 1, 8'h31, 3);
      add(1, 1, 8'h55, 0, 1, 8'h31, 4);
      add(0, 0, 8'h00, 0, 0, 8'h00, 0);
      add(0, 1, 8'h41, 0, 0, 8'h00, 0);
      add(0, 0, 8'h00, 1, 1, 8'h41, 1);
      add(0, 0, 8'h00, 0, 0, 8'h00, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].flush, vecs[i].valid, vecs[i].data, vecs[i].ready);
         #1;
         check($sformatf("v%0d out_valid", i), int'(d5_out_valid), int'(vecs[i].ov));
         if (vecs[i].ov) begin
            check($sformatf("v%0d out_data", i), int'(d5_out_data), int'(vecs[i].od));
         end
         check($sformatf("v%0d usage", i), int'(d5_usage), vecs[i].usage);
         check($sformatf("v%0d full", i), int'(d5_full), int'(vecs[i].usage == 5));
         check($sformatf("v%0d in_ready", i), int'(d5_in_ready), int'(vecs[i].usage != 5));
         check($sformatf("v%0d empty", i), int'(d5_empty), int'(vecs[i].usage == 0));
         check($sformatf("v%0d alm_full", i), int'(d5_af), int'(vecs[i].usage >= 4));
         check($sformatf("v%0d alm_empty", i), int'(d5_ae), int'(vecs[i].usage <= 1));
         check($sformatf("v%0d parity_err", i), int'(d5_perr), 0);
      end

      // Fall-through: empty FIFO passes data the same cycle, count stays 0.
      flush_all();
      @(negedge clk); drive(1'b0, 1'b1, 8'hAB, 1'b1);
      #1;
      check("ft bypass out_valid", int'(ft_out_valid), 1);
      check("ft bypass out_data", int'(ft_out_data), 'hAB);
      check("ft bypass in_ready", int'(ft_in_ready), 1);
      check("nonft same-cycle out_valid", int'(d5_out_valid), 0);
      @(negedge clk); drive(1'b0, 1'b0, 8'h00, 1'b0);
      #1;
      check("ft after bypass usage", int'(ft_usage), 0);
      check("ft after bypass out_valid", int'(ft_out_valid), 0);
      check("nonft next-cycle out_data", int'(d5_out_data), 'hAB);
      // Fall-through with a stalled consumer: word is stored and stays visible.
      @(negedge clk); drive(1'b0, 1'b1, 8'hCD, 1'b0);
      #1;
      check("ft stall out_valid", int'(ft_out_valid), 1);
      check("ft stall out_data", int'(ft_out_data), 'hCD);
      @(negedge clk); drive(1'b0, 1'b1, 8'hEF, 1'b1);
      #1;
      check("ft stored usage", int'(ft_usage), 1);
      check("ft stored out_data", int'(ft_out_data), 'hCD);
      @(negedge clk); drive(1'b0, 1'b0, 8'h00, 1'b0);
      #1;
      check("ft push+pop usage", int'(ft_usage), 1);
      check("ft push+pop out_data", int'(ft_out_data), 'hEF);

      // Thresholds on DEPTH=8, ALM_FULL_TH=6, ALM_EMPTY_TH=2.
      flush_all();
      for (int i = 0; i < 7; i++) begin
         @(negedge clk); drive(1'b0, 1'b1, 8'h60 + 8'(i), 1'b0);
         @(negedge clk); drive(1'b0, 1'b0, 8'h00, 1'b0);
         #1;
         check($sformatf("d8 fill%0d usage", i + 1), int'(d8_usage), i + 1);
         check($sformatf("d8 fill%0d alm_full", i + 1), int'(d8_af), int'(i + 1 >= 6));
         check($sformatf("d8 fill%0d alm_empty", i + 1), int'(d8_ae), int'(i + 1 <= 2));
      end
      for (int j = 0; j < 5; j++) begin
         @(negedge clk); drive(1'b0, 1'b0, 8'h00, 1'b1);
         #1;
         check($sformatf("d8 pop%0d data", j), int'(d8_out_data), 'h60 + j);
         @(negedge clk); drive(1'b0, 1'b0, 8'h00, 1'b0);
         #1;
         check($sformatf("d8 pop%0d usage", j), int'(d8_usage), 6 - j);
         check($sformatf("d8 pop%0d alm_full", j), int'(d8_af), int'(6 - j >= 6));
         check($sformatf("d8 pop%0d alm_empty", j), int'(d8_ae), int'(6 - j <= 2));
      end

      // Asynchronous reset in the middle of a burst.
      flush_all();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); drive(1'b0, 1'b1, 8'h70 + 8'(k), 1'b0);
      end
      @(negedge clk); drive(1'b0, 1'b1, 8'h73, 1'b0);
      #2;
      check("pre-reset d5 usage", int'(d5_usage), 3);
      rst_n = 1'b0; in_valid = 1'b0;
      #1;
      check_idle_all("midreset");
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      #1;
      check_idle_all("postreset");

`ifdef FIFO_V4_PARITY_EN
      // Corrupt the stored head word and watch the flag follow it out.
      @(negedge clk); drive(1'b0, 1'b1, 8'h0F, 1'b0);
      @(negedge clk); drive(1'b0, 1'b1, 8'h05, 1'b0);
      @(negedge clk); drive(1'b0, 1'b0, 8'h00, 1'b0);
      #1;
      check("par clean head", int'(d5_perr), 0);
      force u_d5.mem_q[0] = 9'h00E;
      #1;
      check("par flipped head", int'(d5_perr), 1);
      @(negedge clk); drive(1'b0, 1'b0, 8'h00, 1'b1);
      #1;
      check("par flipped data", int'(d5_out_data), 'h0E);
      @(negedge clk); drive(1'b0, 1'b0, 8'h00, 1'b0);
      release u_d5.mem_q[0];
      #1;
      check("par next head flag", int'(d5_perr), 0);
      check("par next head data", int'(d5_out_data), 'h05);
      check("par usage after pop", int'(d5_usage), 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
